alu_decode_stage: RTL and testbench

- Pipeline stage that sits in front of the 3-bit-control ALU.
- Accepts a 32-bit MIPS-style instruction with its register operands and decodes opcode/funct into the ALU control code.
- Selects and extends the B operand, then registers `a`, `b` and ALUC toward the execute stage.
- Uses a valid/ready handshake on both sides and keeps saturating counters of decoded and illegal instructions.

---
 rtl/alu_decode_stage.sv | 135 +++++++++++++
 tb/tb_alu_decode_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_decode_stage.sv
// Decode stage in front of the 3-bit-control ALU: maps opcode/funct to ALUC, selects and
// extends operand B, and registers the result behind a valid/ready handshake.
module alu_decode_stage #(
  parameter int unsigned CNT_W        = 16,
  parameter logic [2:0]  ILLEGAL_ALUC = 3'b111
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      rt_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [2:0]       aluc,
  output logic             illegal,
  output logic [CNT_W-1:0] decoded_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  logic [5:0]  op, funct;
  logic [31:0] imm_se, imm_ze;
  logic [2:0]  dec_aluc;
  logic [31:0] dec_b;
  logic        dec_illegal;
  logic        accept;

  logic             out_valid_q;
  logic [31:0]      alu_a_q, alu_b_q;
  logic [2:0]       aluc_q;
  logic             illegal_q;
  logic [CNT_W-1:0] decoded_cnt_q, decoded_cnt_d;
  logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

  assign op     = instr[31:26];
  assign funct  = instr[5:0];
  assign imm_se = {{16{instr[15]}}, instr[15:0]};
  assign imm_ze = {16'h0000, instr[15:0]};

  assign in_ready = !rst && !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    dec_aluc    = ILLEGAL_ALUC;
    dec_b       = '0;
    dec_illegal = 1'b1;
    case (op)
      6'h00: begin
        dec_b       = rt_val;
        dec_illegal = 1'b0;
        case (funct)
          6'h20, 6'h21: dec_aluc = 3'b000;
          6'h22, 6'h23: dec_aluc = 3'b001;
          6'h24:        dec_aluc = 3'b010;
          6'h25:        dec_aluc = 3'b011;
          6'h26:        dec_aluc = 3'b100;
          6'h2A:        dec_aluc = 3'b101;
          default: begin
            // Unlisted funct falls back to the illegal encoding.
            dec_b       = '0;
            dec_illegal = 1'b1;
          end
        endcase
      end
      6'h08, 6'h09, 6'h23, 6'h2B: begin
        dec_aluc = 3'b000; dec_b = imm_se; dec_illegal = 1'b0;
      end
      6'h0A: begin
        dec_aluc = 3'b101; dec_b = imm_se; dec_illegal = 1'b0;
      end
      6'h0C: begin
        dec_aluc = 3'b010; dec_b = imm_ze; dec_illegal = 1'b0;
      end
      6'h0D: begin
        dec_aluc = 3'b011; dec_b = imm_ze; dec_illegal = 1'b0;
      end
      6'h0E: begin
        dec_aluc = 3'b100; dec_b = imm_ze; dec_illegal = 1'b0;
      end
      6'h04, 6'h05: begin
        dec_aluc = 3'b001; dec_b = rt_val; dec_illegal = 1'b0;
      end
      default: ;
    endcase
  end

  // Saturating statistics: stick at all-ones instead of wrapping.
  always_comb begin
    decoded_cnt_d = decoded_cnt_q;
    illegal_cnt_d = illegal_cnt_q;
    if (accept) begin
      if (decoded_cnt_q != '1) decoded_cnt_d = decoded_cnt_q + 1'b1;
      if (dec_illegal && (illegal_cnt_q != '1)) illegal_cnt_d = illegal_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      aluc_q        <= '0;
      illegal_q     <= 1'b0;
      decoded_cnt_q <= '0;
      illegal_cnt_q <= '0;
    end else begin
      decoded_cnt_q <= decoded_cnt_d;
      illegal_cnt_q <= illegal_cnt_d;
      if (flush) begin
        out_valid_q <= 1'b0;
      end else if (accept) begin
        out_valid_q <= 1'b1;
        alu_a_q     <= rs_val;
        alu_b_q     <= dec_b;
        aluc_q      <= dec_aluc;
        illegal_q   <= dec_illegal;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign aluc        = aluc_q;
  assign illegal     = illegal_q;
  assign decoded_cnt = decoded_cnt_q;
  assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: directed test-plan cases followed by random traffic,
// with a behavioural handshake/decode model pushing expectations and a monitor popping them.
module tb_alu_decode_stage;

  localparam int unsigned CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  aluc;
    logic        ill;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      instr = '0;
  logic [31:0]      rs_val = '0;
  logic [31:0]      rt_val = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      alu_a, alu_b;
  logic [2:0]       aluc;
  logic             illegal;
  logic [CNT_W-1:0] decoded_cnt, illegal_cnt;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  logic mdl_valid = 1'b0;
  int   mdl_dec = 0;
  int   mdl_ill = 0;

  alu_decode_stage #(.CNT_W(CNT_W), .ILLEGAL_ALUC(3'b111)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr      (instr),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .aluc       (aluc),
    .illegal    (illegal),
    .decoded_cnt(decoded_cnt),
    .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode straight from the instruction table.
  function automatic exp_t ref_decode(logic [31:0] ins, logic [31:0] rs, logic [31:0] rt);
    exp_t r;
    int op, fn;
    logic [31:0] se, ze;
    op = int'(ins[31:26]);
    fn = int'(ins[5:0]);
    se = 32'($signed(ins[15:0]));
    ze = 32'(ins[15:0]);
    r = '{a: rs, b: 32'd0, aluc: 3'd7, ill: 1'b1};
    if (op == 0) begin
      if (fn == 32 || fn == 33) r = '{rs, rt, 3'd0, 1'b0};
      else if (fn == 34 || fn == 35) r = '{rs, rt, 3'd1, 1'b0};
      else if (fn == 36) r = '{rs, rt, 3'd2, 1'b0};
      else if (fn == 37) r = '{rs, rt, 3'd3, 1'b0};
      else if (fn == 38) r = '{rs, rt, 3'd4, 1'b0};
      else if (fn == 42) r = '{rs, rt, 3'd5, 1'b0};
    end
    else if (op == 8 || op == 9 || op == 35 || op == 43) r = '{rs, se, 3'd0, 1'b0};
    else if (op == 10) r = '{rs, se, 3'd5, 1'b0};
    else if (op == 12) r = '{rs, ze, 3'd2, 1'b0};
    else if (op == 13) r = '{rs, ze, 3'd3, 1'b0};
    else if (op == 14) r = '{rs, ze, 3'd4, 1'b0};
    else if (op == 4 || op == 5) r = '{rs, rt, 3'd1, 1'b0};
    return r;
  endfunction

  // Monitor: whenever the DUT presents an entry it must match the scoreboard head.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        check("alu_a", alu_a, q[0].a);
        check("alu_b", alu_b, q[0].b);
        check("aluc", 32'(aluc), 32'(q[0].aluc));
        check("illegal", 32'(illegal), 32'(q[0].ill));
        if (out_ready && !flush && !rst) void'(q.pop_front());
      end
    end
  end

  // Handshake model: predicts in_ready, out_valid and counters, pushes accepted entries.
  always @(negedge clk) begin
    logic exp_ready;
    #1;
    exp_ready = !rst && !flush && (!mdl_valid || out_ready);
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    check("out_valid", 32'(out_valid), 32'(mdl_valid));
    check("decoded_cnt", 32'(decoded_cnt), 32'(mdl_dec));
    check("illegal_cnt", 32'(illegal_cnt), 32'(mdl_ill));
    if (rst) begin
      mdl_valid = 1'b0;
      q.delete();
      mdl_dec = 0;
      mdl_ill = 0;
    end else if (flush) begin
      if (mdl_valid && q.size() > 0) void'(q.pop_front());
      mdl_valid = 1'b0;
    end else begin
      exp_t e;
      if (mdl_valid && out_ready) mdl_valid = 1'b0;
      if (in_valid && exp_ready) begin
        e = ref_decode(instr, rs_val, rt_val);
        q.push_back(e);
        mdl_valid = 1'b1;
        if (mdl_dec < CNT_MAX) mdl_dec++;
        if (e.ill && mdl_ill < CNT_MAX) mdl_ill++;
      end
    end
  end

  task automatic step(input logic r, input logic f, input logic v, input logic rdy,
                      input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    rst = r; flush = f; in_valid = v; out_ready = rdy;
    instr = i; rs_val = a; rt_val = b;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [5:0]  op, fn;
    w = $urandom;
    case ($urandom_range(0, 12))
      0, 1, 2: op = 6'h00;
      3: op = 6'h08;
      4: op = 6'h0A;
      5: op = 6'h0C;
      6: op = 6'h0D;
      7: op = 6'h0E;
      8: op = 6'h23;
      9: op = 6'h2B;
      10: op = 6'h04;
      11: op = 6'h05;
      default: op = 6'($urandom);
    endcase
    case ($urandom_range(0, 8))
      0: fn = 6'h20;
      1: fn = 6'h22;
      2: fn = 6'h24;
      3: fn = 6'h25;
      4: fn = 6'h26;
      5: fn = 6'h2A;
      6: fn = 6'h23;
      default: fn = 6'($urandom);
    endcase
    w[31:26] = op;
    if (op == 6'h00) w[5:0] = fn;
    return w;
  endfunction

  initial begin
    // Reset, then idle with out_ready low.
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // R-type add, then andi / slti with a negative-looking immediate.
    step(0, 0, 1, 1, 32'h012A4020, 32'd5, 32'd7);
    step(0, 0, 1, 1, {6'h0C, 5'd1, 5'd2, 16'hFFF0}, 32'h1234_5678, 32'd9);
    step(0, 0, 1, 1, {6'h0A, 5'd1, 5'd2, 16'hFFF0}, 32'h0000_0003, 32'd9);
    step(0, 0, 0, 1, 0, 0, 0);
    // Backpressure: accept, stall three cycles with new input pending, then release.
    step(0, 0, 1, 0, {6'h00, 15'd0, 5'd0, 6'h25}, 32'hAAAA_0000, 32'h0000_5555);
    step(0, 0, 1, 0, {6'h08, 10'd0, 16'h8001}, 32'd100, 32'd0);
    step(0, 0, 1, 0, {6'h08, 10'd0, 16'h8001}, 32'd100, 32'd0);
    step(0, 0, 1, 0, {6'h08, 10'd0, 16'h8001}, 32'd100, 32'd0);
    step(0, 0, 1, 1, {6'h08, 10'd0, 16'h8001}, 32'd100, 32'd0);
    step(0, 0, 0, 1, 0, 0, 0);
    // Illegal opcode, then flush competing with a valid input.
    step(0, 0, 1, 0, 32'hFC000000, 32'd77, 32'd88);
    step(0, 1, 1, 0, 32'h012A4020, 32'd1, 32'd2);
    step(0, 0, 0, 1, 0, 0, 0);
    // Random traffic: drives the 4-bit counters into saturation and exercises mid-stream reset.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
           rand_instr(), $urandom, $urandom);
    end
    // Long run without reset to reach saturation, then a single-cycle reset.
    for (int n = 0; n < 40; n++) step(0, 0, 1, 1, rand_instr(), $urandom, $urandom);
    step(1, 0, 1, 1, 32'h012A4020, 32'd1, 32'd2);
    step(0, 0, 0, 1, 0, 0, 0);
    for (int n = 0; n < 4; n++) step(0, 0, 0, 1, 0, 0, 0);
    @(posedge clk);
    #2;
    check("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
